// File: rtl/bennett_phase_sequencer.sv
// rtl/bennett_phase_sequencer.sv - adiabatic phase-rail ramp sequencer (optional BENNETT_AUTORUN_EN)
module bennett_phase_sequencer #(
  parameter int WIDTH       = 17,
  parameter int STEP_CYCLES = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(WIDTH+1)-1:0]   depth,
  input  logic                         stall,
  output logic                         ready,
  output logic                         busy,
  output logic                         instFlag,
  output logic [$clog2(WIDTH)-1:0]     phase_idx,
  output logic [WIDTH-1:0]             clkp,
  output logic [WIDTH-1:0]             clkn
);

  localparam int DW   = $clog2(WIDTH + 1);
  localparam int IW   = $clog2(WIDTH);
  localparam int CMAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_HOLD,
    S_FALL,
    S_DONE
  } state_t;

  state_t           state;
  logic [DW-1:0]    depth_q;
  logic [CW-1:0]    cnt;

  logic             go;
  logic [DW-1:0]    depth_clamped;
  logic [DW-1:0]    top_idx;
  logic             at_top;
  logic             at_bottom;
  logic             step_last;
  logic             hold_last;
  logic [WIDTH-1:0] idx_bit;

`ifdef BENNETT_AUTORUN_EN
  // Free-running mode: every idle cycle is an accept; start is deliberately unused.
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  // Zero or out-of-range depth selects the full rail set.
  assign depth_clamped = ((depth == '0) || (depth > DW'(WIDTH))) ? DW'(WIDTH) : depth;

  // Last active rail of the current cycle and the counter terminal conditions.
  assign top_idx   = depth_q - 1'b1;
  assign at_top    = (DW'(phase_idx) == top_idx);
  assign at_bottom = (phase_idx == '0);
  assign step_last = (cnt == CW'(STEP_CYCLES - 1));
  assign hold_last = (cnt == CW'(HOLD_CYCLES - 1));

  // One-hot select of the rail addressed by phase_idx.
  assign idx_bit = WIDTH'(1) << phase_idx;

  // Handshake flags are decoded straight from the state register.
  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);

  // Sequencer FSM: ramps rails up, holds, ramps them down, flags completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      depth_q   <= '0;
      cnt       <= '0;
      phase_idx <= '0;
      clkp      <= '0;
      clkn      <= '1;
      instFlag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            depth_q   <= depth_clamped;
            phase_idx <= '0;
            cnt       <= '0;
            state     <= S_RISE;
          end
        end
        S_RISE: begin
          if (!stall) begin
            if (step_last) begin
              clkp <= clkp | idx_bit;
              clkn <= clkn & ~idx_bit;
              cnt  <= '0;
              if (at_top) begin
                state <= S_HOLD;
              end else begin
                phase_idx <= phase_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if (hold_last) begin
              cnt   <= '0;
              state <= S_FALL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FALL: begin
          if (!stall) begin
            if (step_last) begin
              clkp <= clkp & ~idx_bit;
              clkn <= clkn | idx_bit;
              cnt  <= '0;
              if (at_bottom) begin
                state    <= S_DONE;
                instFlag <= 1'b1;
              end else begin
                phase_idx <= phase_idx - 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!stall) begin
            instFlag <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          instFlag <= 1'b0;
        end
      endcase
    end
  end

endmodule
